wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master Wishbone arbiter in front of the SoC address decoder/slave mux.
- Master 0 is the CPU data port; master 1 is a DMA/debug master (JTAG-driven bus access).
- Grants the single shared bus to one master per Wishbone cycle, with round-robin fairness.
- Routes ack/read data back to the owning master only; can optionally terminate accesses that no slave acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SW = DW/8 byte selects.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins contention.
- TIMEOUT_CYCLES, 255, stb-without-ack cycles before forced termination (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write
- m0_sel  in  SW  master 0 byte select
- m0_adr  in  AW  master 0 address
- m0_dat_w  in  DW  master 0 write data
- m0_dat_r  out  DW  master 0 read data
- m0_ack  out  1  master 0 acknowledge
- m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat_w, m1_dat_r, m1_ack  same as m0_* for master 1
- s_cyc, s_stb, s_we  out  1 each  shared bus cycle/strobe/write
- s_sel  out  SW  shared bus byte select
- s_adr  out  AW  shared bus address
- s_dat_w  out  DW  shared bus write data
- s_dat_r  in  DW  read data from the slave mux
- s_ack  in  1  OR of all slave acks
- grant  out  2  one-hot owner; 00 = idle
- timeout_pulse  out  1  one-cycle pulse on forced termination

Behaviour:
- Reset (async, any time, including mid-transfer):
  - state = IDLE, last_grant = 1 (master 0 wins the first tie).
  - grant = 00; all s_* outputs, m*_ack, m*_dat_r and timeout_pulse = 0.
  - Timeout counter = 0.
- FSM states: IDLE, OWN0, OWN1 (registered).
- IDLE:
  - Only m0_cyc -> OWN0; only m1_cyc -> OWN1.
  - Both asserted -> master != last_grant (round-robin), or master 0 when FIXED_PRIO = 1.
  - Neither -> stay in IDLE.
- OWNx: stay while mx_cyc = 1; last_grant = x on entry.
- Release: when mx_cyc falls, the next state is the other master's OWN if its cyc = 1, else IDLE. No dead cycle on handoff.
- Latency: request -> s_cyc asserted 1 cycle after mx_cyc, because grant is registered.
- Forwarding (combinational):
  - When owned: s_cyc = mx_cyc and s_stb = mx_stb; s_we/sel/adr/dat_w = mx_*.
  - When not owned: all s_* = 0.
- Response routing:
  - mx_ack = s_ack & grant[x]; mx_dat_r = grant[x] ? s_dat_r : 0.
  - A non-owner never sees ack, even if it holds stb.
- Non-owner stall: a master whose cyc is high without a grant simply waits. Its signals are never sampled.
- Block cycles: a master may perform back-to-back stb beats within one cyc. The grant is held for the whole cyc (no preemption).
- Stray input: s_ack while in IDLE is ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - Counter counts cycles with s_stb & !s_ack; it clears on s_ack, on grant change and in IDLE.
  - When count == TIMEOUT_CYCLES, the next cycle:
    - s_stb forced 0;
    - owner sees ack = 1 with dat_r = WB_TIMEOUT_DATA (32'hBADB_0005);
    - timeout_pulse = 1 for exactly one cycle;
    - counter clears.
  - A late s_ack that coincides with the forced termination takes priority: normal data, no pulse.
- Disabled: no counter is synthesised; timeout_pulse is tied 0, and an unmapped access stalls until the master drops cyc.

Decomposition:
- Package wb_arb_pkg:
  - arb_state_t enum {IDLE, OWN0, OWN1};
  - master_idx_t (1-bit);
  - WB_TIMEOUT_DATA constant.
- Sub-module wb_timeout_counter (clk, rst, run, clear, expire; parameter TIMEOUT_CYCLES), instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Single master: m0 reads 0x100 with the slave acking 2 cycles after s_stb, data 0x12345678 -> s_cyc rises 1 cycle after m0_cyc; m0_ack = 1 for 1 cycle with m0_dat_r = 0x12345678; m1_ack stays 0; grant 01 -> 00.
- Contention round-robin: m0 and m1 assert cyc in the same cycle, three times in a row (FIXED_PRIO = 0) -> grant order 01, 10, 01.
  - Each handoff has no IDLE cycle when the other master is already waiting.
- Fixed priority: same stimulus with FIXED_PRIO = 1 -> master 0 wins each simultaneous request.
  - Master 1 is granted only when m0_cyc = 0.
- Block hold: m1 holds cyc across 4 stb/ack beats while m0 requests -> grant stays 10 throughout.
  - m0 is granted the cycle after m1_cyc falls; m0 sees no ack beforehand.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): m0 accesses unmapped 0x2000_0000 with s_ack never asserted -> m0_ack = 1 with dat 0xBADB0005 and timeout_pulse = 1, both on the 9th stb cycle.
  - A repeat with s_ack arriving on the 8th cycle gives normal data and no pulse.
- Reset mid-transfer: assert rst while in OWN1 with s_stb = 1 -> grant = 00, s_cyc = s_stb = 0 immediately (async).
  - After release, m0 requesting together with m1 gets the grant first.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef logic master_idx_t;

   localparam logic [31:0] WB_TIMEOUT_DATA = 32'hBADB_0005;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts stalled strobe cycles; expire is high once the count reaches TIMEOUT_CYCLES.
module wb_timeout_counter
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (run && !expire) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign expire = (r_count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter (round-robin or fixed priority) with owner-only response routing.
// Optional stalled-access termination is built when WB_ARB_TIMEOUT_EN is defined.
module wb_bus_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned FIXED_PRIO     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned SW            = DW / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [SW-1:0] m0_sel,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_dat_w,
   output logic [DW-1:0] m0_dat_r,
   output logic          m0_ack,
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [SW-1:0] m1_sel,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_dat_w,
   output logic [DW-1:0] m1_dat_r,
   output logic          m1_ack,
   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [SW-1:0] s_sel,
   output logic [AW-1:0] s_adr,
   output logic [DW-1:0] s_dat_w,
   input  logic [DW-1:0] s_dat_r,
   input  logic          s_ack,
   output logic [1:0]    grant,
   output logic          timeout_pulse
);

   arb_state_t    r_state;
   arb_state_t    w_next;
   master_idx_t   r_last_grant;
   master_idx_t   w_next_last;
   logic          w_own0;
   logic          w_own1;
   logic          w_stb;
   logic          w_term;
   logic          w_ack;
   logic [DW-1:0] w_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state      <= w_next;
         r_last_grant <= w_next_last;
      end
   end

   // Ownership is held for the whole cyc; release hands straight over to a waiting master.
   always_comb begin
      w_next      = r_state;
      w_next_last = r_last_grant;
      case (r_state)
         IDLE: begin
            if (m0_cyc && m1_cyc) begin
               w_next = ((FIXED_PRIO != 0) || r_last_grant) ? OWN0 : OWN1;
            end else if (m0_cyc) begin
               w_next = OWN0;
            end else if (m1_cyc) begin
               w_next = OWN1;
            end
         end
         OWN0: if (!m0_cyc) w_next = m1_cyc ? OWN1 : IDLE;
         OWN1: if (!m1_cyc) w_next = m0_cyc ? OWN0 : IDLE;
         default: w_next = IDLE;
      endcase
      if (w_next == OWN0) begin
         w_next_last = 1'b0;
      end else if (w_next == OWN1) begin
         w_next_last = 1'b1;
      end
   end

   assign w_own0 = (r_state == OWN0);
   assign w_own1 = (r_state == OWN1);
   assign grant  = {w_own1, w_own0};

   always_comb begin
      s_cyc   = 1'b0;
      w_stb   = 1'b0;
      s_we    = 1'b0;
      s_sel   = '0;
      s_adr   = '0;
      s_dat_w = '0;
      if (w_own0) begin
         s_cyc   = m0_cyc;
         w_stb   = m0_stb;
         s_we    = m0_we;
         s_sel   = m0_sel;
         s_adr   = m0_adr;
         s_dat_w = m0_dat_w;
      end else if (w_own1) begin
         s_cyc   = m1_cyc;
         w_stb   = m1_stb;
         s_we    = m1_we;
         s_sel   = m1_sel;
         s_adr   = m1_adr;
         s_dat_w = m1_dat_w;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic w_expire;

   wb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .run   (w_stb & ~s_ack),
      .clear (s_ack | (r_state == IDLE) | (w_next != r_state) | w_expire),
      .expire(w_expire)
   );

   // A real ack in the expiry cycle wins over the forced termination.
   assign w_term = w_expire & w_stb & ~s_ack;
`else
   assign w_term = 1'b0;

   // TIMEOUT_CYCLES only shapes the optional counter.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_disabled
   end
`endif

   assign s_stb         = w_stb & ~w_term;
   assign timeout_pulse = w_term;
   assign w_ack         = s_ack | w_term;
   assign w_dat         = w_term ? DW'(WB_TIMEOUT_DATA) : s_dat_r;

   assign m0_ack   = w_ack & w_own0;
   assign m1_ack   = w_ack & w_own1;
   assign m0_dat_r = w_own0 ? w_dat : '0;
   assign m1_dat_r = w_own1 ? w_dat : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters share one stimulus stream.
module tb_wb_bus_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [SW-1:0] m0_sel, m1_sel;
   logic [AW-1:0] m0_adr, m1_adr;
   logic [DW-1:0] m0_dat_w, m1_dat_w, s_dat_r;
   logic          s_ack;

   logic [DW-1:0] rr_m0_dat_r, rr_m1_dat_r, rr_s_dat_w;
   logic          rr_m0_ack, rr_m1_ack, rr_s_cyc, rr_s_stb, rr_s_we, rr_pulse;
   logic [SW-1:0] rr_s_sel;
   logic [AW-1:0] rr_s_adr;
   logic [1:0]    rr_grant;

   logic [DW-1:0] fp_m0_dat_r, fp_m1_dat_r, fp_s_dat_w;
   logic          fp_m0_ack, fp_m1_ack, fp_s_cyc, fp_s_stb, fp_s_we, fp_pulse;
   logic [SW-1:0] fp_s_sel;
   logic [AW-1:0] fp_s_adr;
   logic [1:0]    fp_grant;

   int n_chk = 0;
   int n_err = 0;

   logic [1:0] rr_exp [3] = '{2'b01, 2'b10, 2'b01};

   always #5 clk = ~clk;

   wb_bus_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
      .m0_dat_w(m0_dat_w), .m0_dat_r(rr_m0_dat_r), .m0_ack(rr_m0_ack),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
      .m1_dat_w(m1_dat_w), .m1_dat_r(rr_m1_dat_r), .m1_ack(rr_m1_ack),
      .s_cyc(rr_s_cyc), .s_stb(rr_s_stb), .s_we(rr_s_we), .s_sel(rr_s_sel), .s_adr(rr_s_adr),
      .s_dat_w(rr_s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
      .grant(rr_grant), .timeout_pulse(rr_pulse)
   );

   wb_bus_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
      .m0_dat_w(m0_dat_w), .m0_dat_r(fp_m0_dat_r), .m0_ack(fp_m0_ack),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
      .m1_dat_w(m1_dat_w), .m1_dat_r(fp_m1_dat_r), .m1_ack(fp_m1_ack),
      .s_cyc(fp_s_cyc), .s_stb(fp_s_stb), .s_we(fp_s_we), .s_sel(fp_s_sel), .s_adr(fp_s_adr),
      .s_dat_w(fp_s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
      .grant(fp_grant), .timeout_pulse(fp_pulse)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat_w = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_sel = 4'hF; m1_adr = 32'h0000_3000; m1_dat_w = 32'hCAFE_F00D;
      s_dat_r = '0; s_ack = 0;
      step();
      chk("rst_grant", 32'(rr_grant), 32'h0);
      chk("rst_s_cyc", 32'(rr_s_cyc), 32'h0);
      chk("rst_s_stb", 32'(rr_s_stb), 32'h0);
      chk("rst_pulse", 32'(rr_pulse), 32'h0);
      rst = 1'b0;
      step();

      // Single master read with ack two cycles after strobe
      m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_adr = 32'h0000_0100;
      #1;
      chk("t1_s_cyc_pre", 32'(rr_s_cyc), 32'h0);
      step();
      chk("t1_grant", 32'(rr_grant), 32'h1);
      chk("t1_s_cyc", 32'(rr_s_cyc), 32'h1);
      chk("t1_s_adr", rr_s_adr, 32'h0000_0100);
      step();
      step();
      s_ack = 1; s_dat_r = 32'h1234_5678;
      #1;
      chk("t1_m0_ack", 32'(rr_m0_ack), 32'h1);
      chk("t1_m0_dat", rr_m0_dat_r, 32'h1234_5678);
      chk("t1_m1_ack", 32'(rr_m1_ack), 32'h0);
      chk("t1_m1_dat", rr_m1_dat_r, 32'h0);
      step();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      #1;
      chk("t1_m0_ack_off", 32'(rr_m0_ack), 32'h0);
      step();
      chk("t1_grant_idle", 32'(rr_grant), 32'h0);

      // Three simultaneous requests from a fresh reset
      rst = 1; step(); rst = 0; step();
      for (int r = 0; r < 3; r++) begin
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
         step();
         chk($sformatf("rr_grant%0d", r), 32'(rr_grant), 32'(rr_exp[r]));
         chk($sformatf("fp_grant%0d", r), 32'(fp_grant), 32'h1);
         s_ack = 1; s_dat_r = 32'h0000_0040 + 32'(r);
         #1;
         chk($sformatf("rr_m0_ack%0d", r), 32'(rr_m0_ack), 32'(rr_exp[r][0]));
         chk($sformatf("rr_m1_ack%0d", r), 32'(rr_m1_ack), 32'(rr_exp[r][1]));
         step();
         s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
         step();
         chk($sformatf("rr_idle%0d", r), 32'(rr_grant), 32'h0);
      end

      // Handoff without an idle cycle; fixed priority grants m1 only once m0 leaves
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      step();
      chk("ho_rr_grant", 32'(rr_grant), 32'h2);
      chk("ho_fp_grant", 32'(fp_grant), 32'h1);
      m0_cyc = 0; m0_stb = 0;
      step();
      chk("ho_rr_hold", 32'(rr_grant), 32'h2);
      chk("ho_fp_to_m1", 32'(fp_grant), 32'h2);
      m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 1;
      step();
      chk("ho_rr_to_m0", 32'(rr_grant), 32'h1);
      chk("ho_fp_to_m0", 32'(fp_grant), 32'h1);
      m0_cyc = 0; m0_stb = 0;
      step();
      chk("ho_idle", 32'(rr_grant), 32'h0);

      // Block cycle: m1 keeps the bus across four beats while m0 waits
      m1_cyc = 1; m1_stb = 1;
      step();
      chk("blk_grant", 32'(rr_grant), 32'h2);
      m0_cyc = 1; m0_stb = 1;
      for (int b = 0; b < 4; b++) begin
         s_ack = 1; s_dat_r = 32'h0000_00A0 + 32'(b);
         #1;
         chk($sformatf("blk_m1_ack%0d", b), 32'(rr_m1_ack), 32'h1);
         chk($sformatf("blk_m1_dat%0d", b), rr_m1_dat_r, 32'h0000_00A0 + 32'(b));
         chk($sformatf("blk_m0_ack%0d", b), 32'(rr_m0_ack), 32'h0);
         chk($sformatf("blk_s_adr%0d", b), rr_s_adr, 32'h0000_3000);
         step();
         s_ack = 0;
         #1;
         chk($sformatf("blk_hold%0d", b), 32'(rr_grant), 32'h2);
         step();
      end
      m1_cyc = 0; m1_stb = 0;
      #1;
      chk("blk_still_m1", 32'(rr_grant), 32'h2);
      chk("blk_m0_noack", 32'(rr_m0_ack), 32'h0);
      step();
      chk("blk_to_m0", 32'(rr_grant), 32'h1);
      chk("blk_s_adr_m0", rr_s_adr, 32'h0000_0100);
      m0_cyc = 0; m0_stb = 0;
      step();

      // Asynchronous reset while m1 owns the bus
      m1_cyc = 1; m1_stb = 1;
      step();
      chk("rm_grant", 32'(rr_grant), 32'h2);
      chk("rm_s_stb", 32'(rr_s_stb), 32'h1);
      #2;
      rst = 1;
      #1;
      chk("rm_grant_rst", 32'(rr_grant), 32'h0);
      chk("rm_s_cyc_rst", 32'(rr_s_cyc), 32'h0);
      chk("rm_s_stb_rst", 32'(rr_s_stb), 32'h0);
      m0_cyc = 1; m0_stb = 1;
      step();
      rst = 0;
      step();
      chk("rm_rr_m0_first", 32'(rr_grant), 32'h1);
      chk("rm_fp_m0_first", 32'(fp_grant), 32'h1);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      step();
      chk("rm_idle", 32'(rr_grant), 32'h0);

`ifdef WB_ARB_TIMEOUT_EN
      // Unmapped access: forced termination on the ninth strobe cycle
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2000_0000;
      step();
      repeat (7) step();
      chk("to_c8_ack", 32'(rr_m0_ack), 32'h0);
      chk("to_c8_pulse", 32'(rr_pulse), 32'h0);
      step();
      chk("to_c9_ack", 32'(rr_m0_ack), 32'h1);
      chk("to_c9_dat", rr_m0_dat_r, 32'hBADB_0005);
      chk("to_c9_pulse", 32'(rr_pulse), 32'h1);
      chk("to_c9_stb", 32'(rr_s_stb), 32'h0);
      step();
      chk("to_c10_pulse", 32'(rr_pulse), 32'h0);
      chk("to_c10_ack", 32'(rr_m0_ack), 32'h0);
      m0_cyc = 0; m0_stb = 0;
      step();
      // Ack on the eighth cycle: normal completion
      m0_cyc = 1; m0_stb = 1;
      step();
      repeat (7) step();
      s_ack = 1; s_dat_r = 32'h0000_0055;
      #1;
      chk("tl_ack", 32'(rr_m0_ack), 32'h1);
      chk("tl_dat", rr_m0_dat_r, 32'h0000_0055);
      chk("tl_pulse", 32'(rr_pulse), 32'h0);
      step();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      #1;
      chk("tl_pulse_after", 32'(rr_pulse), 32'h0);
      step();
`else
      chk("no_to_pulse", 32'(rr_pulse), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
